xalu_seq: RTL and testbench
===========================

XALU_SEQ -- requirements
Module: xalu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits, legal range 4..32.
REQ-002 SHALL have localparam SHAMT_W = $clog2(WIDTH), the shift-amount field width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  block can accept a request; high only in IDLE.
REQ-007 op  in  4  function code, per REQ-012.
REQ-008 a, b  in  WIDTH  operands; ci  in  1  carry/fill input; com  in  1  ones-complement output mode.
REQ-009 out_valid  out  1  result available; out_ready  in  1  consumer accepts the result.
REQ-010 result  out  WIDTH; co  out  1  carry/shift-out; equ, zero, neg_zero  out  1  status flags.
REQ-011 busy  out  1  high in any state other than IDLE.

Function
REQ-012 Op codes: 0 ADD a+b+ci; 1 AND; 2 OR; 3 XOR; 4 PASSA; 5 PASSB; 6 SHR; 7 SHL; 8 SUB a+~b+1, ci ignored; 9 MUL; 10-15 illegal.
REQ-013 A request SHALL be accepted on a cycle with in_valid && in_ready; a, b, op, ci and com SHALL be captured at acceptance and inputs ignored afterwards.
REQ-014 States: IDLE, SHIFT, MUL, DONE.
REQ-015 Single-cycle ops (0-5, 8, illegal) SHALL go IDLE->DONE, so out_valid rises 1 cycle after acceptance.
REQ-016 SHR/SHL SHALL shift by k = b[SHAMT_W-1:0], one bit per cycle in SHIFT, then go to DONE; out_valid rises k+1 cycles after acceptance.
REQ-017 When k = 0, a shift SHALL go directly IDLE->DONE with result = a and co = 0.
REQ-018 SHR SHALL fill the MSB with ci, and co SHALL equal the last bit shifted out of the LSB.
REQ-019 SHL SHALL fill the LSB with ci, and co SHALL equal the last bit shifted out of the MSB.
REQ-020 ADD co SHALL be the carry out of the MSB; SUB co SHALL be 1 when there is no borrow (a >= b unsigned).
REQ-021 Logic and pass ops SHALL produce co = 0.
REQ-022 An illegal op SHALL produce result 0 and co 0.
REQ-023 DONE SHALL hold out_valid = 1 with result and flags stable until out_ready = 1, then return to IDLE.
REQ-024 No new request SHALL be accepted in the cycle out_ready is seen.
REQ-025 result SHALL equal the raw result XOR {WIDTH{com}}; co SHALL NOT be inverted by com.
REQ-026 zero = (result == 0) and neg_zero = (result == all ones), both evaluated on the final, post-com result.
REQ-027 equ = (captured a == captured b).
REQ-028 All outputs SHALL be registered, except in_ready and busy, which are decoded from state.

Reset
REQ-029 While rst is high: state IDLE; out_valid, result, co, equ, zero, neg_zero and busy = 0; in_ready = 1.
REQ-030 rst asserted mid-operation SHALL abort the operation with no result delivered; the first cycle after rst deasserts SHALL be IDLE.

Configuration
REQ-031 Macro XALU_MUL_EN defined: op 9 SHALL be an unsigned shift-add multiply.
- one partial-product step per cycle in MUL, WIDTH cycles, then DONE.
- result = low WIDTH bits of a*b.
- co = OR of the high WIDTH bits (overflow).
REQ-032 Macro XALU_MUL_EN undefined: the MUL state and multiplier logic SHALL be absent, and op 9 SHALL behave as illegal per REQ-022.

Structure
REQ-033 Package xalu_pkg SHALL hold the op-code enum, the state enum and the illegal-op result constant.
REQ-034 Sub-module xalu_core SHALL implement the combinational single-cycle ops (0-5, 8) with carry; xalu_seq holds the FSM, shifter and multiplier.

Verification (WIDTH=8)
REQ-035 ADD a=0xF0, b=0x20, ci=0 -> result 0x10, co=1, out_valid 1 cycle after acceptance.
REQ-036 SUB a=0x33, b=0x33 -> result 0x00, zero=1, equ=1, co=1.
REQ-037 SHL a=0x81, b=0x03, ci=0 -> result 0x08, co=0, out_valid 4 cycles after acceptance, busy high meanwhile.
REQ-038 PASSA a=0x00, com=1 -> result 0xFF, neg_zero=1, zero=0.
REQ-039 Backpressure: out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout; after out_ready pulse -> IDLE, next request accepted.
REQ-040 rst pulse during SHR by 7 -> out_valid never asserted; MUL 0x10*0x10 gives result 0x00, co=1 with XALU_MUL_EN defined, and result 0x00, co=0 without it.

Source files
------------

// File: rtl/xalu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xalu_pkg
//  Description : Shared types and constants for the sequential ALU slice.
//                This package holds the function-code enum, the controller
//                state enum and the result value returned for an illegal op.
//                The optional multiplier is selected by the XALU_MUL_EN
//                macro in xalu_seq.
//  Revision    : 1.0  initial release
// ============================================================================
package xalu_pkg;

    // Function codes. Codes 10-15 are illegal. Code 9 is illegal when the
    // multiplier is not built.
    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_AND   = 4'd1,
        OP_OR    = 4'd2,
        OP_XOR   = 4'd3,
        OP_PASSA = 4'd4,
        OP_PASSB = 4'd5,
        OP_SHR   = 4'd6,
        OP_SHL   = 4'd7,
        OP_SUB   = 4'd8,
        OP_MUL   = 4'd9
    } op_e;

    // Controller states. The encoding is fixed so that it stays
    // legacy-compatible.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Raw result for an illegal op. It is sliced to the datapath width at
    // the point of use.
    localparam logic [31:0] c_ILLEGAL_RESULT = 32'h0000_0000;

    // SHR and SHL are the two serial shift codes.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xalu_core.sv
`default_nettype none
// ============================================================================
//  Module      : xalu_core
//  Description : Combinational single-cycle ALU functions: ADD, AND, OR, XOR,
//                PASSA, PASSB and SUB, with carry out. Any other code returns
//                the illegal-op result with co = 0.
//  Revision    : 1.0  initial release
// ============================================================================
module xalu_core
    import xalu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ci,
    output logic [WIDTH-1:0] o_result,
    output logic             o_co
);

    logic [WIDTH:0] w_add;
    logic [WIDTH:0] w_sub;

    // The extra MSB carries the adder carry-out. For SUB, a carry out means
    // there was no borrow (a >= b, unsigned).
    assign w_add = {1'b0, i_a} + {1'b0, i_b}  + {{WIDTH{1'b0}}, i_ci};
    assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};

    // Select the function result. Logic and pass ops never produce a carry.
    always_comb begin
        o_result = c_ILLEGAL_RESULT[WIDTH-1:0];
        o_co     = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_add[WIDTH-1:0];
                o_co     = w_add[WIDTH];
            end
            OP_AND:   o_result = i_a & i_b;
            OP_OR:    o_result = i_a | i_b;
            OP_XOR:   o_result = i_a ^ i_b;
            OP_PASSA: o_result = i_a;
            OP_PASSB: o_result = i_b;
            OP_SUB: begin
                o_result = w_sub[WIDTH-1:0];
                o_co     = w_sub[WIDTH];
            end
            default: begin
                o_result = c_ILLEGAL_RESULT[WIDTH-1:0];
                o_co     = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/xalu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : xalu_seq
//  Description : Sequential ALU with a valid/ready request and result
//                handshake. Single-cycle ops come from xalu_core. SHR and SHL
//                shift one bit per cycle. When the XALU_MUL_EN macro is
//                defined, op 9 is a shift-add multiply that takes WIDTH
//                cycles.
//  Config      : XALU_MUL_EN - build the serial multiplier (op 9).
//  Revision    : 1.0  initial release
// ============================================================================
module xalu_seq
    import xalu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             com,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             equ,
    output logic             zero,
    output logic             neg_zero,
    output logic             busy
);

    localparam int SHAMT_W = $clog2(WIDTH);
    // One bit wider than the shift amount, so the counter can also hold
    // WIDTH for the multiplier.
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // Controller state and per-operation context
    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic               r_shr;
    logic               r_ci;
    logic               r_com;
    logic               r_equ_cap;

    // Registered outputs
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_co;
    logic               r_equ;
    logic               r_zero;
    logic               r_neg_zero;

    // Signals that load a final result into the output registers
    logic               w_accept;
    logic               w_load;
    logic [WIDTH-1:0]   w_raw_res;
    logic               w_raw_co;
    logic               w_fin_com;
    logic               w_fin_equ;
    logic [WIDTH-1:0]   w_fin_res;

    logic [SHAMT_W-1:0] w_k;
    logic [WIDTH-1:0]   w_core_res;
    logic               w_core_co;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic               w_shift_co;

`ifdef XALU_MUL_EN
    // Product register {hi, lo}. lo starts as the multiplier and is
    // consumed one bit per step as the partial sums shift down into it.
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_hi;
    logic [WIDTH-1:0]   r_mul_lo;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi_nxt;
    logic [WIDTH-1:0]   w_mul_lo_nxt;

    assign w_mul_sum    = {1'b0, r_mul_hi} + (r_mul_lo[0] ? {1'b0, r_mul_a} : {(WIDTH+1){1'b0}});
    assign w_mul_hi_nxt = w_mul_sum[WIDTH:1];
    assign w_mul_lo_nxt = {w_mul_sum[0], r_mul_lo[WIDTH-1:1]};
`endif

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_k       = b[SHAMT_W-1:0];
    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign co        = r_co;
    assign equ       = r_equ;
    assign zero      = r_zero;
    assign neg_zero  = r_neg_zero;

    xalu_core #(
        .WIDTH    (WIDTH)
    ) u_core (
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .i_ci     (ci),
        .o_result (w_core_res),
        .o_co     (w_core_co)
    );

    // One step of the serial shifter. The vacated end takes the captured ci.
    assign w_shift_nxt = r_shr ? {r_ci, r_acc[WIDTH-1:1]} : {r_acc[WIDTH-2:0], r_ci};
    assign w_shift_co  = r_shr ? r_acc[0] : r_acc[WIDTH-1];

    // The final result includes the complement mode. Both status flags
    // look at this post-complement value.
    assign w_fin_res = w_raw_res ^ {WIDTH{w_fin_com}};

    // Next state, and selection of the result that enters DONE this cycle
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_raw_res   = '0;
        w_raw_co    = 1'b0;
        w_fin_com   = r_com;
        w_fin_equ   = r_equ_cap;
        case (r_state)
            ST_IDLE: begin
                // Single-cycle results use the live inputs at acceptance
                w_fin_com = com;
                w_fin_equ = (a == b);
                if (in_valid) begin
                    if (is_shift_op(op)) begin
                        if (w_k == '0) begin
                            w_load      = 1'b1;
                            w_raw_res   = a;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_SHIFT;
                        end
                    end
`ifdef XALU_MUL_EN
                    else if (op == OP_MUL) begin
                        w_state_nxt = ST_MUL;
                    end
`endif
                    else begin
                        w_load      = 1'b1;
                        w_raw_res   = w_core_res;
                        w_raw_co    = w_core_co;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_load      = 1'b1;
                    w_raw_res   = w_shift_nxt;
                    w_raw_co    = w_shift_co;
                    w_state_nxt = ST_DONE;
                end
            end
`ifdef XALU_MUL_EN
            ST_MUL: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_load      = 1'b1;
                    w_raw_res   = w_mul_lo_nxt;
                    w_raw_co    = |w_mul_hi_nxt;
                    w_state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register. Reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the request at acceptance and advance the multi-cycle datapaths
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_shr     <= 1'b0;
            r_ci      <= 1'b0;
            r_com     <= 1'b0;
            r_equ_cap <= 1'b0;
`ifdef XALU_MUL_EN
            r_mul_a   <= '0;
            r_mul_hi  <= '0;
            r_mul_lo  <= '0;
`endif
        end else if (w_accept) begin
            r_cnt     <= {1'b0, w_k};
            r_acc     <= a;
            r_shr     <= (op == OP_SHR);
            r_ci      <= ci;
            r_com     <= com;
            r_equ_cap <= (a == b);
`ifdef XALU_MUL_EN
            r_mul_a   <= a;
            r_mul_hi  <= '0;
            r_mul_lo  <= b;
            if (op == OP_MUL) begin
                r_cnt <= CNT_W'(WIDTH);
            end
`endif
        end else if (r_state == ST_SHIFT) begin
            r_acc <= w_shift_nxt;
            r_cnt <= r_cnt - c_CNT_ONE;
        end
`ifdef XALU_MUL_EN
        else if (r_state == ST_MUL) begin
            r_mul_hi <= w_mul_hi_nxt;
            r_mul_lo <= w_mul_lo_nxt;
            r_cnt    <= r_cnt - c_CNT_ONE;
        end
`endif
    end

    // Output registers. They load on the way into DONE and hold until the
    // consumer takes the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_co        <= 1'b0;
            r_equ       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg_zero  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_fin_res;
            r_co        <= w_raw_co;
            r_equ       <= w_fin_equ;
            r_zero      <= (w_fin_res == '0);
            r_neg_zero  <= (&w_fin_res);
        end else if ((r_state == ST_DONE) && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xalu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xalu_seq
//  Description : Self-checking bench for xalu_seq at WIDTH=8. It runs
//                directed cases followed by random requests, and compares
//                each one against an arithmetic reference model. Define
//                XALU_MUL_EN to match the build of the design under test.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_xalu_seq;

    localparam int W = 8;
`ifdef XALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         com = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         co;
    logic         equ;
    logic         zero;
    logic         neg_zero;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    xalu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .com       (com),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .co        (co),
        .equ       (equ),
        .zero      (zero),
        .neg_zero  (neg_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model. It computes the result and latency directly from the
    // arithmetic meaning of each op.
    task automatic model(input int o, input int av, input int bv, input int civ, input int comv,
                         output logic [W-1:0] e_res, output logic e_co, output int e_lat);
        int raw, c, k, p;
        raw = 0; c = 0; e_lat = 1;
        k = bv % 8;
        case (o)
            0: begin p = av + bv + civ; raw = p % 256; c = p / 256; end
            1: raw = av & bv;
            2: raw = av | bv;
            3: raw = av ^ bv;
            4: raw = av;
            5: raw = bv;
            6: begin
                if (k == 0) raw = av;
                else begin
                    raw = (av >> k) | (civ != 0 ? ((255 << (8 - k)) & 255) : 0);
                    c   = (av >> (k - 1)) & 1;
                    e_lat = k + 1;
                end
            end
            7: begin
                if (k == 0) raw = av;
                else begin
                    raw = ((av << k) | (civ != 0 ? ((1 << k) - 1) : 0)) & 255;
                    c   = (av >> (8 - k)) & 1;
                    e_lat = k + 1;
                end
            end
            8: begin raw = (av - bv) & 255; c = (av >= bv) ? 1 : 0; end
            9: begin
                if (MUL_EN) begin
                    p = av * bv; raw = p % 256; c = (p >= 256) ? 1 : 0; e_lat = W + 1;
                end
            end
            default: begin raw = 0; c = 0; end
        endcase
        if (comv != 0) raw = raw ^ 255;
        e_res = raw[W-1:0];
        e_co  = c[0];
    endtask

    // Issue one request, wait for its result, apply backpressure for hold
    // cycles, then release the result.
    task automatic do_op(input string tag, input int o, input int av, input int bv, input int civ,
                         input int comv, input int hold, output logic [W-1:0] r_obs, output logic co_obs);
        logic [W-1:0] e_res;
        logic e_co;
        int e_lat, n;
        model(o, av, bv, civ, comv, e_res, e_co, e_lat);
        chk({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op = o[3:0]; a = av[W-1:0]; b = bv[W-1:0]; ci = civ[0]; com = comv[0];
        @(posedge clk); #1;
        // Change the inputs after acceptance. The design must ignore them.
        in_valid = 1'b0;
        op = 4'($urandom); a = W'($urandom); b = W'($urandom);
        ci = 1'($urandom); com = 1'($urandom);
        n = 1;
        while (!out_valid && n < 64) begin
            chk({tag, ".busy_wait"}, {30'd0, busy, in_ready}, 32'd2);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, n, e_lat);
        chk({tag, ".result"}, {24'd0, result}, {24'd0, e_res});
        chk({tag, ".co"}, {31'd0, co}, {31'd0, e_co});
        chk({tag, ".equ"}, {31'd0, equ}, (av == bv) ? 32'd1 : 32'd0);
        chk({tag, ".zero"}, {31'd0, zero}, (e_res == 0) ? 32'd1 : 32'd0);
        chk({tag, ".neg_zero"}, {31'd0, neg_zero}, (e_res == 8'hFF) ? 32'd1 : 32'd0);
        r_obs = result; co_obs = co;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_result"}, {24'd0, result}, {24'd0, e_res});
            chk({tag, ".hold_valid_ready"}, {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;   // no request may be accepted in the out_ready cycle
        op = 4'd4;
        #1;
        chk({tag, ".no_accept_on_release"}, {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, ".released"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [W-1:0] r;
        logic c;
        bit seen;

        // Outputs must hold their reset values while rst is high
        @(posedge clk); #1;
        chk("reset.outputs", {24'd0, result}, 32'd0);
        chk("reset.flags", {27'd0, out_valid, co, equ, zero, neg_zero}, 32'd0);
        chk("reset.busy_ready", {30'd0, busy, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("add", 0, 'hF0, 'h20, 0, 0, 0, r, c);
        chk("add.lit", {23'd0, c, r}, {23'd0, 1'b1, 8'h10});

        do_op("sub_eq", 8, 'h33, 'h33, 1, 0, 0, r, c);
        chk("sub_eq.lit", {23'd0, c, r}, {23'd0, 1'b1, 8'h00});

        do_op("shl3", 7, 'h81, 'h03, 0, 0, 0, r, c);
        chk("shl3.lit", {23'd0, c, r}, {23'd0, 1'b0, 8'h08});

        do_op("passa_com", 4, 'h00, 'h5A, 0, 1, 0, r, c);
        chk("passa_com.lit", {24'd0, r}, 32'hFF);

        do_op("backpressure", 3, 'hA5, 'h0F, 0, 0, 5, r, c);
        do_op("after_bp", 1, 'hCC, 'hAA, 0, 0, 0, r, c);

        do_op("shr_k0", 6, 'h9B, 'h08, 1, 0, 0, r, c);
        do_op("shr7_ci", 6, 'h80, 'h07, 1, 0, 0, r, c);
        do_op("shl7_ci", 7, 'h03, 'h07, 1, 1, 1, r, c);
        do_op("sub_borrow", 8, 'h10, 'h20, 0, 0, 0, r, c);
        do_op("illegal", 12, 'h12, 'h34, 1, 0, 0, r, c);
        do_op("illegal_com", 15, 'h12, 'h34, 1, 1, 0, r, c);

        do_op("mul", 9, 'h10, 'h10, 0, 0, 0, r, c);
        chk("mul.lit", {23'd0, c, r}, {23'd0, MUL_EN, 8'h00});
        do_op("mul_ff", 9, 'hFF, 'hFF, 0, 0, 0, r, c);

        // A reset during a long shift must drop the operation
        in_valid = 1'b1; op = 4'd6; a = 8'hF3; b = 8'h07; ci = 1'b1; com = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst.state", {29'd0, busy, in_ready, out_valid}, 32'd2);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("midrst.no_result", {31'd0, seen}, 32'd0);
        chk("midrst.idle", {30'd0, busy, in_ready}, 32'd1);

        // Random requests across all codes, including illegal ones
        for (int i = 0; i < 40; i++) begin
            do_op("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), r, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case the sequence itself stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
